// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master: turns a valid/ready command stream into single AXI4-Lite transactions.
// Optional watchdog: define AXI_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module axi4_lite_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t state;
    logic   wr_q;
    logic   aw_pend;
    logic   w_pend;
    logic   tmo_hit;
    logic   tmo_fire;

    assign awprot    = 3'b000;
    assign arprot    = 3'b000;
    assign cmd_ready = rst && (state == IDLE);
    assign busy      = (state != IDLE);
    assign aw_pend   = awvalid && !awready;
    assign w_pend    = wvalid && !wready;

`ifdef AXI_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (cmd_valid && cmd_ready) begin
            tmo_cnt <= '0;
        end else if (state == WR_AW_W || state == WR_B ||
                     state == RD_AR || state == RD_R) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // A handshake finishing on the limit edge wins over the watchdog.
    always_comb begin
        tmo_fire = 1'b0;
        unique case (state)
            WR_AW_W: tmo_fire = tmo_hit && (aw_pend || w_pend);
            WR_B:    tmo_fire = tmo_hit && !bvalid;
            RD_AR:   tmo_fire = tmo_hit && !arready;
            RD_R:    tmo_fire = tmo_hit && !rvalid;
            default: tmo_fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            araddr    <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            rsp_write <= 1'b0;
        end else if (tmo_fire) begin
            // Recovery path: drop every AXI handshake signal and report SLVERR.
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b10;
            rsp_rdata <= '0;
            rsp_write <= wr_q;
            state     <= RSP;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q <= cmd_write;
                        if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_AW_W;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (!aw_pend && !w_pend) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_B;
                    end else begin
                        if (awready) awvalid <= 1'b0;
                        if (wready)  wvalid  <= 1'b0;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        rsp_write <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= rresp;
                        rsp_rdata <= rdata;
                        rsp_write <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master: directed bench with a small AXI4-Lite memory slave.
// Define AXI_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_axi4_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic        b_hold = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;

    always #5 clk = ~clk;

    axi4_lite_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .busy(busy)
    );

    // Memory slave: B/R response appears one cycle after the address/data handshake.
    logic        aw_got, w_got, pend_b, pend_r;
    logic [31:0] sa, sd, ra;
    logic [31:0] mem [0:15];

    always @(posedge clk) begin
        if (!rst) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            pend_b <= 1'b0;
            pend_r <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            bresp  <= 2'b00;
            rresp  <= 2'b00;
            rdata  <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                sa     <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1;
                sd    <= wdata;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                pend_b <= 1'b1;
            end
            if (pend_b && !b_hold) begin
                pend_b       <= 1'b0;
                bvalid       <= 1'b1;
                bresp        <= bresp_cfg;
                mem[sa[5:2]] <= sd;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                pend_r <= 1'b1;
                ra     <= araddr;
            end
            if (pend_r) begin
                pend_r <= 1'b0;
                rvalid <= 1'b1;
                rdata  <= mem[ra[5:2]];
                rresp  <= rresp_cfg;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_cmd_ready: got %b, expected 0", cmd_ready);
        end
        tests++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_handshakes: got %b, expected 0000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy});
        end
        tests++;
        if ({awaddr, araddr, rsp_rdata, rsp_resp, rsp_write, awprot, arprot} !== '0) begin
            fails++;
            $display("FAIL reset_payload: awaddr %h araddr %h rdata %h resp %b, expected zeros",
                     awaddr, araddr, rsp_rdata, rsp_resp);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_cmd_ready: got %b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic;
        awready   = 1'b1;
        wready    = 1'b1;
        bresp_cfg = 2'b00;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'hDEADBEEF;
        cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if ({awvalid, wvalid, busy, awaddr, wdata, wstrb} !== {3'b111, 32'h10, 32'hDEADBEEF, 4'hF}) begin
            fails++;
            $display("FAIL wr_issue: aw %b w %b addr %h data %h strb %h, expected 1 1 10 deadbeef f",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        tick();
        tests++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            fails++;
            $display("FAIL wr_handshake: got aw/w/b %b, expected 001", {awvalid, wvalid, bready});
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL wr_early_rsp: got rsp_valid %b at N+2, expected 0", rsp_valid);
        end
        tick();
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, bready} !== {2'b11, 2'b00, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL wr_rsp: valid %b write %b resp %b rdata %h, expected 1 1 00 0",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL wr_done: got valid/busy %b, expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_read_stall;
        arready   = 1'b1;
        rresp_cfg = 2'b00;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if ({arvalid, araddr} !== {1'b1, 32'h10}) begin
            fails++;
            $display("FAIL rd_issue: arvalid %b araddr %h, expected 1 10", arvalid, araddr);
        end
        tick();
        tick();
        tick();
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL rd_rsp: valid %b write %b resp %b rdata %h, expected 1 0 00 deadbeef",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({rsp_valid, rsp_rdata, cmd_ready, awvalid, arvalid} !== {1'b1, 32'hDEADBEEF, 3'b000}) begin
                fails++;
                $display("FAIL rsp_stall_%0d: valid %b rdata %h cmd_ready %b aw %b ar %b, expected 1 deadbeef 0 0 0",
                         i, rsp_valid, rsp_rdata, cmd_ready, awvalid, arvalid);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, busy, awvalid} !== 3'b000) begin
            fails++;
            $display("FAIL rd_done: got valid/busy/aw %b, expected 000", {rsp_valid, busy, awvalid});
        end
    endtask

    task automatic test_wready_delay;
        bit seen;
        awready   = 1'b1;
        wready    = 1'b0;
        bresp_cfg = 2'b10;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h14;
        cmd_wdata = 32'h12345678;
        cmd_wstrb = 4'b0011;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if ({awvalid, wvalid, wstrb} !== {2'b11, 4'b0011}) begin
            fails++;
            $display("FAIL wd_issue: aw %b w %b strb %b, expected 1 1 0011", awvalid, wvalid, wstrb);
        end
        tick();
        tests++;
        if (awvalid !== 1'b0) begin
            fails++;
            $display("FAIL wd_aw_drop: got awvalid %b, expected 0", awvalid);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) tick();
            tests++;
            if ({wvalid, wdata, awvalid, bready} !== {1'b1, 32'h12345678, 2'b00}) begin
                fails++;
                $display("FAIL wd_hold_%0d: w %b data %h aw %b b %b, expected 1 12345678 0 0",
                         i, wvalid, wdata, awvalid, bready);
            end
        end
        wready = 1'b1;
        tick();
        tests++;
        if ({wvalid, bready} !== 2'b01) begin
            fails++;
            $display("FAIL wd_w_done: got w/b %b, expected 01", {wvalid, bready});
        end
        tick();
        tick();
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp} !== {2'b11, 2'b10}) begin
            fails++;
            $display("FAIL wd_rsp: valid %b write %b resp %b, expected 1 1 10",
                     rsp_valid, rsp_write, rsp_resp);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL wd_single_rsp: got extra activity %b, expected 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        awready   = 1'b1;
        wready    = 1'b1;
        b_hold    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h18;
        cmd_wdata = 32'hCAFEF00D;
        cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tests++;
        if (bready !== 1'b1) begin
            fails++;
            $display("FAIL rm_in_wr_b: got bready %b, expected 1", bready);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready} !== 8'b0) begin
            fails++;
            $display("FAIL rm_cleared: got %b, expected 00000000",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready});
        end
        rst    = 1'b1;
        b_hold = 1'b0;
        tick();
        tick();
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rm_no_rsp: got rsp_valid %b, expected 0", rsp_valid);
        end
        arready   = 1'b1;
        rresp_cfg = 2'b01;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {2'b10, 2'b01, 32'hDEADBEEF} || n != 3) begin
            fails++;
            $display("FAIL rm_read_after: valid %b write %b resp %b rdata %h latency %0d, expected 1 0 01 deadbeef 3",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata, n);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        awready   = 1'b1;
        wready    = 1'b1;
        arready   = 1'b1;
        bresp_cfg = 2'b11;
        rresp_cfg = 2'b00;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h1C;
        cmd_wdata = 32'h0BADF00D;
        cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp} !== {2'b11, 2'b11} || n != 3) begin
            fails++;
            $display("FAIL b2b_wr: valid %b write %b resp %b latency %0d, expected 1 1 11 3",
                     rsp_valid, rsp_write, rsp_resp, n);
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h1C;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++;
        if ({busy, arvalid, cmd_ready} !== 3'b001) begin
            fails++;
            $display("FAIL b2b_gap: got busy/ar/cmd_ready %b, expected 001", {busy, arvalid, cmd_ready});
        end
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (arvalid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got arvalid %b, expected 1", arvalid);
        end
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h0BADF00D} || n != 3) begin
            fails++;
            $display("FAIL b2b_rd: valid %b write %b resp %b rdata %h latency %0d, expected 1 0 00 0badf00d 3",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata, n);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

`ifdef AXI_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        arready   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h24;
        tick();
        cmd_valid = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (!arvalid || rsp_valid) ok = 1'b0;
            tick();
        end
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL to_wait: arvalid/rsp_valid changed before limit, got ok %b, expected 1", ok);
        end
        tick();
        tests++;
        if ({arvalid, rsp_valid, rsp_resp, rsp_rdata, rsp_write} !== {2'b01, 2'b10, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL to_fire: ar %b valid %b resp %b rdata %h, expected 0 1 10 0",
                     arvalid, rsp_valid, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        arready   = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_wready_delay();
        test_reset_mid();
        test_back_to_back();
`ifdef AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_lite_cmd_master.md
Name: axi4_lite_cmd_master

Overview:
- Upstream feeder for the AXI4-Lite register/BRAM slave.
- Converts a simple valid/ready command stream from the host-side control logic into single AXI4-Lite write or read transactions.
- Returns each transaction's response on a valid/ready response stream.
- One transaction outstanding at a time; strict command order.

Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles per transaction. Used only with AXI_TIMEOUT_EN. Legal range 2..65535.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  32  byte address
- cmd_wdata  input  32  write data; ignored for reads
- cmd_wstrb  input  4  write byte strobes; ignored for reads
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_write  output  1  echo of cmd_write for this response
- rsp_rdata  output  32  read data; 0 for writes
- rsp_resp  output  2  AXI resp code (bresp/rresp, or timeout code)
- awaddr  output  32  write address
- awprot  output  3  constant 3'b000
- awvalid  output  1  write address valid
- awready  input  1  write address ready
- wdata  output  32  write data
- wstrb  output  4  write strobes
- wvalid  output  1  write data valid
- wready  input  1  write data ready
- bresp  input  2  write response
- bvalid  input  1  write response valid
- bready  output  1  write response ready
- araddr  output  32  read address
- arprot  output  3  constant 3'b000
- arvalid  output  1  read address valid
- arready  input  1  read address ready
- rdata  input  32  read data
- rresp  input  2  read response
- rvalid  input  1  read data valid
- rready  output  1  read data ready
- busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- Reset (rst=0 at a clock edge):
  - state goes to IDLE.
  - All valid/ready outputs go to 0. This includes cmd_ready, which is 0 while rst=0.
  - awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp and rsp_write go to 0.
  - Reset mid-transaction abandons it silently; no response is produced.
- IDLE:
  - cmd_ready = 1 (combinational from state and rst).
  - On a cmd_valid && cmd_ready edge, addr/wdata/wstrb/write are registered.
  - A write goes to WR_AW_W; a read goes to RD_AR.
  - awvalid/wvalid (or arvalid) are registered outputs, first high the cycle after acceptance.
- WR_AW_W:
  - awvalid and wvalid start high together.
  - Each is cleared independently on the edge where its own ready is sampled high. Either order is allowed, including the same cycle.
  - Valids and payload stay stable until the handshake.
  - Go to WR_B once both handshakes have completed.
- WR_B:
  - bready = 1.
  - On bvalid, register bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, and go to RSP.
- RD_AR:
  - arvalid high until arready is sampled, then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid, register rdata and rresp, set rsp_write=0, and go to RSP.
- RSP:
  - rsp_valid = 1 (registered).
  - Response fields are held stable until rsp_ready.
  - On the handshake, go to IDLE. The next command can be accepted on the following cycle at the earliest.
- Minimum latency against a zero-wait slave:
  - Write: command accepted at edge N, rsp_valid high after edge N+3.
  - Read: same, N+3.
- No command is accepted while busy.
- bvalid/rvalid seen outside WR_B/RD_R are ignored.
- Response codes 2'b01, 2'b10 and 2'b11 are passed through unchanged; the block takes no other action on them.

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter is cleared on command acceptance and increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES-1, on the next edge all AXI valid/ready outputs drop to 0 and the block goes to RSP with rsp_resp=2'b10 and rsp_rdata=0.
  - This deliberately breaks AXI handshake rules, as a recovery path.
  - A handshake completing on the same edge as the timeout takes priority over the timeout.
- Undefined:
  - No counter is built.
  - The block waits indefinitely in any state.

Test Plan:
- Zero-wait slave; write addr 0x10, data 0xDEADBEEF, wstrb 0xF -> aw/w handshake one cycle after accept; rsp_valid at N+3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read addr 0x10 after that write, against the BRAM slave -> rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0.
- Write where awready is high at once and wready is held low 5 cycles -> awvalid drops after 1 cycle; wvalid is held 6 cycles with data stable; exactly one response.
- Hold rsp_ready low 4 cycles after a read -> rsp_valid and fields stay stable, cmd_ready stays 0, no new AXI activity; IDLE the cycle after rsp_ready.
- Assert rst=0 while in WR_B -> all valids/readys 0 after the edge, no rsp_valid; a new read after reset completes normally.
- AXI_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready tied 0 -> arvalid drops and rsp_valid rises with rsp_resp=2'b10 eight cycles after arvalid first rose.
